// File: rtl/nano_alu_arbiter.sv
// nano_alu_arbiter: round-robin arbiter and sequencer for the shared 8-bit ALU.
// Accepts one request at a time from two requesters, holds the operands on
// the ALU for a fixed settle time, captures result/flags, then returns the
// response to the requester that issued the operation.
module nano_alu_arbiter #(
    parameter int MULDIV_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req0_unsigned,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic       req1_unsigned,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp_data,
    output logic [7:0] rsp_rem,
    output logic [5:0] rsp_flags,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    output logic       alu_unsigned,
    input  logic [7:0] alu_result,
    input  logic [7:0] alu_remainder,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    input  logic       alu_underflow,
    input  logic       alu_div_by_zero,
    input  logic [1:0] alu_comp,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] MULDIV_LOAD = 3'(MULDIV_WAIT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last_grant;
    logic       r_owner;
    logic [3:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_uns;
    logic [2:0] r_cnt;
    logic [7:0] r_rsp_data;
    logic [7:0] r_rsp_rem;
    logic [5:0] r_rsp_flags;

    logic       w_gnt;
    logic       w_idle;
    logic       w_accept;
    logic       w_rsp_take;
    logic       w_cap;
    logic [3:0] w_sel_op;
    logic [7:0] w_sel_a;
    logic [7:0] w_sel_b;
    logic       w_sel_uns;
    logic [7:0] w_cap_data;
    logic [7:0] w_cap_rem;
    logic [5:0] w_cap_flags;

    // Grant selection: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        w_gnt = req1_valid;
        if (req0_valid && req1_valid) begin
            w_gnt = ~r_last_grant;
        end
    end

    // Ready is gated by rst_n so nothing is offered while reset is held.
    assign w_idle     = (r_state == IDLE) && rst_n;
    assign req0_ready = w_idle && req0_valid && !w_gnt;
    assign req1_ready = w_idle && req1_valid && w_gnt;
    assign w_accept   = req0_ready || req1_ready;
    assign w_rsp_take = (r_state == RESP) && (r_owner ? rsp1_ready : rsp0_ready);
    assign w_cap      = (r_state == EXEC) && (r_cnt == 3'd0);

    assign w_sel_op  = w_gnt ? req1_op       : req0_op;
    assign w_sel_a   = w_gnt ? req1_a        : req0_a;
    assign w_sel_b   = w_gnt ? req1_b        : req0_b;
    assign w_sel_uns = w_gnt ? req1_unsigned : req0_unsigned;

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_nxt = EXEC;
            EXEC:    if (w_cap)      w_state_nxt = RESP;
            RESP:    if (w_rsp_take) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Response shaping: div-by-zero is resolved here, compare keeps only comp.
    always_comb begin
        w_cap_data  = alu_result;
        w_cap_rem   = 8'h00;
        w_cap_flags = {alu_div_by_zero, alu_underflow, alu_overflow, alu_zero, 2'b00};
        if (r_op == 4'b1100 || r_op == 4'b1101) begin
            if (r_b == 8'h00) begin
                w_cap_data  = 8'h00;
                w_cap_rem   = r_a;
                w_cap_flags = 6'b100000;
            end else begin
                w_cap_rem = alu_remainder;
            end
        end
        if (r_op == 4'b1111) begin
            w_cap_data  = 8'h00;
            w_cap_flags = {4'b0000, alu_comp};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the granted request and load the settle counter on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_op         <= 4'h0;
            r_a          <= 8'h00;
            r_b          <= 8'h00;
            r_uns        <= 1'b0;
            r_cnt        <= 3'd0;
        end else if (w_accept) begin
            r_last_grant <= w_gnt;
            r_owner      <= w_gnt;
            r_op         <= w_sel_op;
            r_a          <= w_sel_a;
            r_b          <= w_sel_b;
            r_uns        <= w_sel_uns;
            r_cnt        <= (w_sel_op >= 4'b1010 && w_sel_op <= 4'b1101) ? MULDIV_LOAD : 3'd0;
        end else if (r_state == EXEC && r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    // Capture the ALU outputs on the last EXEC cycle; held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data  <= 8'h00;
            r_rsp_rem   <= 8'h00;
            r_rsp_flags <= 6'b000000;
        end else if (w_cap) begin
            r_rsp_data  <= w_cap_data;
            r_rsp_rem   <= w_cap_rem;
            r_rsp_flags <= w_cap_flags;
        end
    end

    assign alu_a        = r_a;
    assign alu_b        = r_b;
    assign alu_op       = r_op;
    assign alu_unsigned = r_uns;
    assign rsp_data     = r_rsp_data;
    assign rsp_rem      = r_rsp_rem;
    assign rsp_flags    = r_rsp_flags;
    assign rsp0_valid   = (r_state == RESP) && !r_owner;
    assign rsp1_valid   = (r_state == RESP) && r_owner;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_nano_alu_arbiter.sv
// Testbench for nano_alu_arbiter: behavioural ALU attached to the ALU port,
// table vectors, random operations against a reference model, and
// hand-written tie, stall and reset sequences.
module tb_nano_alu_arbiter;

    localparam int MW = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_unsigned;
    logic [3:0] req0_op;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_unsigned;
    logic [3:0] req1_op;
    logic [7:0] req1_a, req1_b;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0] rsp_data, rsp_rem;
    logic [5:0] rsp_flags;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_op;
    logic       alu_unsigned;
    logic [7:0] alu_result, alu_remainder;
    logic       alu_zero, alu_overflow, alu_underflow, alu_div_by_zero;
    logic [1:0] alu_comp;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nano_alu_arbiter #(.MULDIV_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_unsigned(req0_unsigned),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_unsigned(req1_unsigned),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_rem(rsp_rem), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_unsigned(alu_unsigned),
        .alu_result(alu_result), .alu_remainder(alu_remainder),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_underflow(alu_underflow), .alu_div_by_zero(alu_div_by_zero),
        .alu_comp(alu_comp), .busy(busy)
    );

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] rem;
        logic       zero;
        logic       ov;
        logic       uf;
        logic       dbz;
        logic [1:0] comp;
    } alu_t;

    // Behavioural ALU. Remainder output is junk for non-div ops, the compare
    // output is always live, and div-by-zero leaves a junk result.
    function automatic alu_t alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic uns);
        alu_t o;
        int sa, sb, p;
        sa = uns ? int'(a) : int'($signed(a));
        sb = uns ? int'(b) : int'($signed(b));
        o.res = 8'h00; o.rem = 8'h5A; o.ov = 1'b0; o.uf = 1'b0; o.dbz = 1'b0;
        o.comp = (sa < sb) ? 2'b00 : ((sa == sb) ? 2'b01 : 2'b10);
        p = 0;
        case (op)
            4'd0, 4'd2: begin
                p = sa + sb; o.res = p[7:0];
                o.ov = uns ? (p > 255) : (p > 127 || p < -128);
            end
            4'd1, 4'd3: begin
                p = sa - sb; o.res = p[7:0];
                o.uf = uns ? (p < 0) : (p > 127 || p < -128);
            end
            4'd4: o.res = a & b;
            4'd5: o.res = a | b;
            4'd6: o.res = a ^ b;
            4'd7: o.res = a << b[2:0];
            4'd8: o.res = a >> b[2:0];
            4'd9: o.res = ~(a & b);
            4'd10, 4'd11: begin
                p = sa * sb; o.res = p[7:0];
                o.ov = uns ? (p > 255) : (p > 127 || p < -128);
            end
            4'd12, 4'd13: begin
                if (b == 8'h00) begin
                    o.res = 8'hEE; o.rem = 8'hEE; o.dbz = 1'b1;
                end else begin
                    p = sa / sb; o.res = p[7:0];
                    p = sa % sb; o.rem = p[7:0];
                end
            end
            4'd14: o.res = ~a;
            default: begin
                p = sa - sb; o.res = p[7:0];
            end
        endcase
        o.zero = (o.res == 8'h00);
        return o;
    endfunction

    // Reference response {data, rem, flags} from the capture rules.
    function automatic logic [21:0] exp_rsp(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic uns);
        alu_t       o;
        logic [7:0] d, r;
        logic [5:0] f;
        o = alu_f(op, a, b, uns);
        d = o.res; r = 8'h00; f = {o.dbz, o.uf, o.ov, o.zero, 2'b00};
        if (op == 4'd12 || op == 4'd13) begin
            if (b == 8'h00) begin d = 8'h00; r = a; f = 6'b100000; end
            else r = o.rem;
        end
        if (op == 4'd15) begin d = 8'h00; f = {4'b0000, o.comp}; end
        return {d, r, f};
    endfunction

    alu_t w_alu;
    always_comb w_alu = alu_f(alu_op, alu_a, alu_b, alu_unsigned);
    assign alu_result      = w_alu.res;
    assign alu_remainder   = w_alu.rem;
    assign alu_zero        = w_alu.zero;
    assign alu_overflow    = w_alu.ov;
    assign alu_underflow   = w_alu.uf;
    assign alu_div_by_zero = w_alu.dbz;
    assign alu_comp        = w_alu.comp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int port, input logic v, input logic [3:0] op,
                           input logic [7:0] a, input logic [7:0] b, input logic uns);
        if (port == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_unsigned = uns;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_unsigned = uns;
        end
    endtask

    function automatic logic ready_of(input int port);
        return (port == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic rsp_valid_of(input int port);
        return (port == 0) ? rsp0_valid : rsp1_valid;
    endfunction

    task automatic set_rsp_ready(input int port, input logic v);
        if (port == 0) rsp0_ready = v; else rsp1_ready = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ready"}, 32'({req0_ready, req1_ready}), 32'(0));
        chk({tag, " rsp_valid"}, 32'({rsp0_valid, rsp1_valid}), 32'(0));
        chk({tag, " rsp"}, 32'({rsp_data, rsp_rem, rsp_flags}), 32'(0));
        chk({tag, " alu"}, 32'({alu_a, alu_b, alu_op, alu_unsigned}), 32'(0));
        chk({tag, " busy"}, 32'(busy), 32'(0));
    endtask

    // One full transaction on a port, checking latency, payload, stall behaviour
    // (hold > 0 keeps rsp_ready low and raises the other requester meanwhile).
    task automatic do_op(input string tag, input int port, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic uns,
                         input int hold, input logic [7:0] ed, input logic [7:0] er,
                         input logic [5:0] ef);
        int         n, cnt;
        bit         got, rdy_seen;
        logic [21:0] snap;
        n = (op >= 4'd10 && op <= 4'd13) ? 1 + MW : 1;
        @(posedge clk); #1;
        set_req(port, 1'b1, op, a, b, uns);
        #1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (ready_of(port)) begin got = 1; break; end
            @(posedge clk); #2;
        end
        chk({tag, " accept"}, 32'(got), 32'(1));
        if (!got) begin
            set_req(port, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
            return;
        end
        @(posedge clk); #1;
        set_req(port, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        #1;
        chk({tag, " busy"}, 32'(busy), 32'(1));
        cnt = 1; got = 0; rdy_seen = 0;
        while (cnt <= n + 8) begin
            if (rsp_valid_of(port)) begin got = 1; break; end
            rdy_seen = rdy_seen | req0_ready | req1_ready;
            @(posedge clk); #2;
            cnt++;
        end
        chk({tag, " ready outside idle"}, 32'(rdy_seen), 32'(0));
        chk({tag, " latency"}, got ? 32'(cnt) : 32'hFFFF_FFFF, 32'(n + 1));
        if (!got) return;
        chk({tag, " data"}, 32'(rsp_data), 32'(ed));
        chk({tag, " rem"}, 32'(rsp_rem), 32'(er));
        chk({tag, " flags"}, 32'(rsp_flags), 32'(ef));
        chk({tag, " other rsp"}, 32'(rsp_valid_of(1 - port)), 32'(0));
        snap = {rsp_data, rsp_rem, rsp_flags};
        if (hold > 0) set_req(1 - port, 1'b1, 4'h5, 8'h01, 8'h02, 1'b0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #2;
            chk({tag, " stall valid"}, 32'(rsp_valid_of(port)), 32'(1));
            chk({tag, " stall stable"}, 32'({rsp_data, rsp_rem, rsp_flags}), 32'(snap));
            chk({tag, " stall other ready"}, 32'(ready_of(1 - port)), 32'(0));
        end
        set_rsp_ready(port, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(port, 1'b0);
        #1;
        chk({tag, " rsp dropped"}, 32'(rsp_valid_of(port)), 32'(0));
        chk({tag, " idle"}, 32'(busy), 32'(0));
        if (hold > 0) begin
            chk({tag, " waiter offered"}, 32'(ready_of(1 - port)), 32'(1));
            set_req(1 - port, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        end
    endtask

    // Both requesters valid continuously; responses must alternate starting at req0.
    task automatic tie_run(input string tag, input int count, input bit do_reset);
        int seen;
        set_req(0, 1'b1, 4'h4, 8'hF0, 8'h3C, 1'b0);
        set_req(1, 1'b1, 4'h5, 8'hF0, 8'h0F, 1'b0);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        if (do_reset) begin
            rst_n = 1'b0;
            #1;
            chk({tag, " ready in reset"}, 32'({req0_ready, req1_ready}), 32'(0));
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
        end
        seen = 0;
        for (int c = 0; c < 20 * count && seen < count; c++) begin
            @(posedge clk); #2;
            if (rsp0_valid || rsp1_valid) begin
                chk($sformatf("%s port%0d", tag, seen), 32'(rsp1_valid), 32'(seen % 2));
                chk($sformatf("%s data%0d", tag, seen), 32'(rsp_data),
                    (seen % 2 == 0) ? 32'h30 : 32'hFF);
                seen++;
                if (seen == count) begin
                    req0_valid = 1'b0; req1_valid = 1'b0;
                end
            end
        end
        chk({tag, " responses"}, 32'(seen), 32'(count));
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    typedef struct {
        int         port;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       uns;
        int         hold;
        logic [7:0] d;
        logic [7:0] r;
        logic [5:0] f;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int          port, hold;
        logic [3:0]  op;
        logic [7:0]  a, b;
        logic        uns;
        logic [21:0] e;
        bit          got, seen_rsp;

        tbl[0] = '{0, 4'b0000, 8'h70, 8'h20, 1'b0, 0, 8'h90, 8'h00, 6'b001000};
        tbl[1] = '{0, 4'b0100, 8'hF0, 8'h3C, 1'b0, 0, 8'h30, 8'h00, 6'b000000};
        tbl[2] = '{1, 4'b0101, 8'hF0, 8'h0F, 1'b0, 0, 8'hFF, 8'h00, 6'b000000};
        tbl[3] = '{1, 4'b1010, 8'h10, 8'h10, 1'b0, 0, 8'h00, 8'h00, 6'b001100};
        tbl[4] = '{0, 4'b1100, 8'h07, 8'h00, 1'b0, 0, 8'h00, 8'h07, 6'b100000};
        tbl[5] = '{0, 4'b1100, 8'h07, 8'h02, 1'b0, 0, 8'h03, 8'h01, 6'b000000};
        tbl[6] = '{0, 4'b1111, 8'h05, 8'h09, 1'b0, 5, 8'h00, 8'h00, 6'b000000};

        rst_n = 1'b0;
        set_req(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        set_req(1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        tie_run("tie", 4, 1'b1);

        for (int i = 0; i < 7; i++)
            do_op($sformatf("vec%0d", i), tbl[i].port, tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].uns, tbl[i].hold, tbl[i].d, tbl[i].r, tbl[i].f);

        for (int i = 0; i < 40; i++) begin
            port = int'($urandom_range(0, 1));
            op   = 4'($urandom_range(0, 15));
            a    = 8'($urandom);
            b    = 8'($urandom);
            if ($urandom_range(0, 3) == 0) b = 8'h00;
            uns  = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(0, 2));
            e    = exp_rsp(op, a, b, uns);
            do_op($sformatf("rnd%0d", i), port, op, a, b, uns, hold, e[21:14], e[13:6], e[5:0]);
        end

        // Reset in the middle of a req0 multiply: op dropped, tie goes back to req0.
        @(posedge clk); #1;
        set_req(0, 1'b1, 4'b1010, 8'h03, 8'h04, 1'b0);
        #1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (req0_ready) begin got = 1; break; end
            @(posedge clk); #2;
        end
        chk("drop accept", 32'(got), 32'(1));
        @(posedge clk); #1;
        set_req(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        chk("drop busy before reset", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk_all_zero("drop");
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_rsp = 0;
        repeat (10) begin
            @(posedge clk); #2;
            seen_rsp = seen_rsp | rsp0_valid | rsp1_valid;
        end
        chk("drop no response", 32'(seen_rsp), 32'(0));
        tie_run("post-drop tie", 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nano_alu_arbiter.md
# nano_alu_arbiter

Two-port arbiter and sequencer for the shared nanoRisc 8-bit arithmetic unit. It accepts operation requests from two requesters (stack-side instruction paths 0 and 1) using valid/ready handshakes and grants them round-robin. It drives the operands into the combinational ALU, waits a fixed settle time, then captures the result and flags. It returns the captured response to the granted requester through a second valid/ready handshake. One operation is in flight at a time.

## Interface
Parameters:
- MULDIV_WAIT, default 1: extra settle cycles for ops 1010–1101 (mul/muli/div/divi). Legal range is 0–7.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  4  ALU opcode, 0000–1111
- req0_a, req0_b / req1_a, req1_b  in  8  operands
- req0_unsigned / req1_unsigned  in  1  unsigned-mode select
- rsp0_valid / rsp1_valid  out  1  response present for that requester
- rsp0_ready / rsp1_ready  in  1  requester takes the response
- rsp_data  out  8  result (shared by both response ports)
- rsp_rem  out  8  remainder (div ops only, else 0)
- rsp_flags  out  6  {div_by_zero, underflow, overflow, zero, comp[1:0]}
- alu_a, alu_b  out  8  ALU operands
- alu_op  out  4  ALU opcode
- alu_unsigned  out  1  ALU unsigned-mode select
- alu_result, alu_remainder  in  8  ALU outputs
- alu_zero, alu_overflow, alu_underflow, alu_div_by_zero  in  1  ALU flags
- alu_comp  in  2  ALU compare result
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE, grant selection:
  - Exactly one requester valid: that requester is granted.
  - Both valid: the requester not granted last time (last_grant) wins.
  - reqN_ready is asserted combinationally, only for the granted requester and only in IDLE.
  - When valid & ready, the op, a, b and unsigned select are latched and last_grant is updated; the state goes to EXEC.
- EXEC:
  - alu_* outputs are driven from the latched registers and stay stable for the whole EXEC stay.
  - A counter loads N−1 on entry, where N = 1 for non-mul/div ops and N = 1 + MULDIV_WAIT for ops 1010–1101.
  - On the cycle the counter reads 0, the response registers capture the ALU outputs and the state goes to RESP.
- Capture rules:
  - Ops 1100/1101 with b = 0: rsp_data = 0x00, rsp_rem = a, div_by_zero = 1, all other flags 0. The ALU's stale result is ignored.
  - Ops 1100/1101 with b ≠ 0: rsp_rem = alu_remainder.
  - All other ops: rsp_rem = 0.
  - Op 1111: rsp_data = 0x00, comp = alu_comp, all other flags 0.
  - Ops other than 1111: comp = 00.
  - Op 1110 uses a only; b is still driven unchanged.
- RESP:
  - rspN_valid = 1 for the granted requester only.
  - rsp_data, rsp_rem and rsp_flags are held stable until rspN_ready = 1.
  - On that handshake cycle the state goes to IDLE and rspN_valid drops the next cycle.
- rspN_ready held low in RESP: the block stalls indefinitely and blocks the other requester.
- A requester's request inputs are ignored while its grant is outstanding.

## Timing
- Reset values (asynchronous, on rst_n low):
  - State IDLE; last_grant = 1, so req0 wins the first tie.
  - All outputs 0: reqN_ready, rspN_valid, rsp_data, rsp_rem, rsp_flags, alu_a, alu_b, alu_op, alu_unsigned, busy.
- Latency: request accepted in cycle T → EXEC in T+1 … T+N → rspN_valid high from T+N+1.
- Minimum occupancy per op is N+2 cycles when the response is taken immediately. The next accept is possible in the cycle after the response handshake.
- reqN_ready never asserts outside IDLE.
- A request arriving in the same cycle as the response handshake waits one cycle.
- Reset mid-EXEC or mid-RESP: the operation is dropped, no response is issued, and last_grant returns to 1.
- Deasserting reqN_valid before the handshake is legal; the arbiter simply re-evaluates the grant.

## Test plan
- Reset, then req0 add (0000), a = 0x70, b = 0x20, signed, rsp0_ready = 1 → rsp0_valid at T+2, rsp_data = 0x90, overflow = 1, zero = 0, comp = 00. busy is high T+1 … T+2.
- req0 and req1 both valid continuously from reset with ops 0100 (0xF0 & 0x3C) and 0101 (0xF0 | 0x0F) → req0 served first with rsp_data 0x30. req1 is served next with 0xFF; grants then alternate.
- MULDIV_WAIT = 2, req1 mul 0x10 × 0x10 → rsp1_valid exactly at T+4, rsp_data = 0x00, zero = 1.
- req0 div 0x07 / 0x00 → rsp_data = 0x00, rsp_rem = 0x07, div_by_zero = 1. Then div 0x07 / 0x02 → rsp_data = 0x03, rsp_rem = 0x01, div_by_zero = 0.
- Compare 0x05 vs 0x09 with rsp0_ready held low for 5 cycles → rsp0_valid stays high, rsp_flags = 000000 stable, req1_ready stays 0. Then rsp0_ready = 1 → IDLE next cycle.
- Assert rst_n low during EXEC → all outputs 0 immediately. No response is ever issued for the dropped op, and the next tie goes to req0.
